// File: rtl/pipeline_defs.sv
// pipeline_defs: shared widths, flag bit positions, memory-stage FSM encoding
// and the MEM/WB pipeline-register layout.
package pipeline_defs;

    localparam int DATA_W     = 16;
    localparam int REG_ADDR_W = 3;
    localparam int CCR_W      = 3;

    // Condition-code bit positions: {carry, negative, zero}
    localparam int CCR_C = 2;
    localparam int CCR_N = 1;
    localparam int CCR_Z = 0;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_e;

    // MEM/WB register contents; an all-zero value is a bubble.
    typedef struct packed {
        logic                  reg_write;
        logic [REG_ADDR_W-1:0] wr_addr;
        logic [DATA_W-1:0]     wb_data;
        logic [DATA_W-1:0]     sext;
        logic [CCR_W-1:0]      ccr;
        logic [DATA_W-1:0]     rd_data2;
    } memwb_t;

endpackage

// File: rtl/data_memory.sv
// data_memory: 2^ADDR_W x 16-bit word RAM, synchronous write, asynchronous
// read, no reset (contents survive a pipeline reset).
// Ports: clk, addr[ADDR_W], wdata[16], we, rdata[16].
module data_memory
    import pipeline_defs::*;
#(
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              we,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) r_mem[addr] <= wdata;
    end

    assign rdata = r_mem[addr];

endmodule

// File: rtl/var_reg.sv
// var_reg: plain D register, async active-high clear, loads every cycle.
// Ports: clk, rst, d[WIDTH], q[WIDTH].
module var_reg #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) q <= '0;
        else     q <= d;
    end

endmodule

// File: rtl/memory_stage.sv
// memory_stage: consumer of the EX/MEM register. Performs the data-memory
// load/store, inserts wait states when MEM_LATENCY > 1 (stalling upstream and
// feeding bubbles into MEM/WB), and loads the MEM/WB register.
//
// Ports:
//   clk, reset (async, active-high)
//   EX/MEM in : result_r, conditionCodeRegister_r, RegWrite_r,
//               reg_write_address_to_memory, sign_extend_to_memory,
//               write_back_select_to_memory, reg_file_read_data1_to_mem,
//               reg_file_read_data2_to_mem, memRead_to_mem, memWrite_to_mem
//   out       : stall (comb), mem_fault, *_to_wb MEM/WB register outputs
//
// Optional: define MEM_ADDR_CHECK_EN to fault accesses whose upper address
// bits (result_r[15:ADDR_W]) are non-zero; otherwise they alias.
module memory_stage
    import pipeline_defs::*;
#(
    parameter int ADDR_W      = 11,
    parameter int MEM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_W-1:0]     result_r,
    input  logic [CCR_W-1:0]      conditionCodeRegister_r,
    input  logic                  RegWrite_r,
    input  logic [REG_ADDR_W-1:0] reg_write_address_to_memory,
    input  logic [DATA_W-1:0]     sign_extend_to_memory,
    input  logic                  write_back_select_to_memory,
    input  logic [DATA_W-1:0]     reg_file_read_data1_to_mem,
    input  logic [DATA_W-1:0]     reg_file_read_data2_to_mem,
    input  logic                  memRead_to_mem,
    input  logic                  memWrite_to_mem,
    output logic                  stall,
    output logic                  mem_fault,
    output logic                  RegWrite_to_wb,
    output logic [REG_ADDR_W-1:0] reg_write_address_to_wb,
    output logic [DATA_W-1:0]     write_back_data_to_wb,
    output logic [DATA_W-1:0]     sign_extend_to_wb,
    output logic [CCR_W-1:0]      conditionCodeRegister_to_wb,
    output logic [DATA_W-1:0]     reg_file_read_data2_to_wb
);

    localparam bit         MULTI    = (MEM_LATENCY > 1);
    // WAIT is entered after the first cycle and left on the last one, so the
    // counter covers the MEM_LATENCY-2 cycles in between.
    localparam logic [3:0] CNT_INIT = MULTI ? 4'(MEM_LATENCY - 2) : 4'd0;

    mem_state_e        r_state;
    logic [3:0]        r_cnt;

    logic              w_access;
    logic              w_complete;
    logic              w_fault;
    logic              w_we;
    logic [DATA_W-1:0] w_rdata;
    logic [DATA_W-1:0] w_load;
    memwb_t            w_memwb_d;
    memwb_t            w_memwb_q;
    logic              w_fault_d;

    assign w_access = memRead_to_mem | memWrite_to_mem;

`ifdef MEM_ADDR_CHECK_EN
    assign w_fault = w_access && ((result_r >> ADDR_W) != '0);
`else
    assign w_fault = 1'b0;
`endif

    // Completing edge: single-cycle access from IDLE, or last WAIT cycle.
    // Reset is folded in so a held access cannot commit or stall under reset.
    always_comb begin
        w_complete = 1'b0;
        stall      = 1'b0;
        if (!reset) begin
            if (r_state == IDLE) begin
                w_complete = w_access && !MULTI;
                stall      = w_access && MULTI;
            end else begin
                w_complete = (r_cnt == 4'd0);
                stall      = (r_cnt != 4'd0);
            end
        end
    end

    assign w_we   = w_complete && memWrite_to_mem && !w_fault;
    assign w_load = w_fault ? '0 : w_rdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_access && MULTI) begin
                        r_cnt   <= CNT_INIT;
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (r_cnt != 4'd0) r_cnt   <= r_cnt - 4'd1;
                    else               r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    data_memory #(.ADDR_W(ADDR_W)) u_dmem (
        .clk   (clk),
        .addr  (result_r[ADDR_W-1:0]),
        .wdata (reg_file_read_data1_to_mem),
        .we    (w_we),
        .rdata (w_rdata)
    );

    // Memory data only on a pure load with select=1; a store (or load+store)
    // writes back the ALU result; select=1 without a read yields 0.
    always_comb begin
        w_memwb_d = '0;
        if (!stall) begin
            w_memwb_d.reg_write = RegWrite_r;
            w_memwb_d.wr_addr   = reg_write_address_to_memory;
            w_memwb_d.sext      = sign_extend_to_memory;
            w_memwb_d.ccr       = conditionCodeRegister_r;
            w_memwb_d.rd_data2  = reg_file_read_data2_to_mem;
            if (!write_back_select_to_memory || memWrite_to_mem)
                w_memwb_d.wb_data = result_r;
            else if (memRead_to_mem)
                w_memwb_d.wb_data = w_load;
            else
                w_memwb_d.wb_data = '0;
        end
    end

    var_reg #(.WIDTH($bits(memwb_t))) u_memwb (
        .clk (clk),
        .rst (reset),
        .d   (w_memwb_d),
        .q   (w_memwb_q)
    );

    assign w_fault_d = w_complete && w_fault;

    var_reg #(.WIDTH(1)) u_fault (
        .clk (clk),
        .rst (reset),
        .d   (w_fault_d),
        .q   (mem_fault)
    );

    assign RegWrite_to_wb              = w_memwb_q.reg_write;
    assign reg_write_address_to_wb     = w_memwb_q.wr_addr;
    assign write_back_data_to_wb       = w_memwb_q.wb_data;
    assign sign_extend_to_wb           = w_memwb_q.sext;
    assign conditionCodeRegister_to_wb = w_memwb_q.ccr;
    assign reg_file_read_data2_to_wb   = w_memwb_q.rd_data2;

endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: three memory_stage instances (latency 1, 3, 4) share one
// EX/MEM stimulus; each check looks only at the instance under test.
module tb_memory_stage;

`ifdef MEM_ADDR_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] res, d1, d2, se;
    logic [2:0]  cc, wa;
    logic        rw, wbsel, mrd, mwr;

    logic        st1, ft1, rw1, st3, ft3, rw3, st4, ft4, rw4;
    logic [2:0]  wa1, cc1, wa3, cc3, wa4, cc4;
    logic [15:0] wd1, se1, o21, wd3, se3, o23, wd4, se4, o24;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    memory_stage #(.ADDR_W(11), .MEM_LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset), .result_r(res), .conditionCodeRegister_r(cc),
        .RegWrite_r(rw), .reg_write_address_to_memory(wa), .sign_extend_to_memory(se),
        .write_back_select_to_memory(wbsel), .reg_file_read_data1_to_mem(d1),
        .reg_file_read_data2_to_mem(d2), .memRead_to_mem(mrd), .memWrite_to_mem(mwr),
        .stall(st1), .mem_fault(ft1), .RegWrite_to_wb(rw1), .reg_write_address_to_wb(wa1),
        .write_back_data_to_wb(wd1), .sign_extend_to_wb(se1),
        .conditionCodeRegister_to_wb(cc1), .reg_file_read_data2_to_wb(o21));

    memory_stage #(.ADDR_W(11), .MEM_LATENCY(3)) u_dut3 (
        .clk(clk), .reset(reset), .result_r(res), .conditionCodeRegister_r(cc),
        .RegWrite_r(rw), .reg_write_address_to_memory(wa), .sign_extend_to_memory(se),
        .write_back_select_to_memory(wbsel), .reg_file_read_data1_to_mem(d1),
        .reg_file_read_data2_to_mem(d2), .memRead_to_mem(mrd), .memWrite_to_mem(mwr),
        .stall(st3), .mem_fault(ft3), .RegWrite_to_wb(rw3), .reg_write_address_to_wb(wa3),
        .write_back_data_to_wb(wd3), .sign_extend_to_wb(se3),
        .conditionCodeRegister_to_wb(cc3), .reg_file_read_data2_to_wb(o23));

    memory_stage #(.ADDR_W(11), .MEM_LATENCY(4)) u_dut4 (
        .clk(clk), .reset(reset), .result_r(res), .conditionCodeRegister_r(cc),
        .RegWrite_r(rw), .reg_write_address_to_memory(wa), .sign_extend_to_memory(se),
        .write_back_select_to_memory(wbsel), .reg_file_read_data1_to_mem(d1),
        .reg_file_read_data2_to_mem(d2), .memRead_to_mem(mrd), .memWrite_to_mem(mwr),
        .stall(st4), .mem_fault(ft4), .RegWrite_to_wb(rw4), .reg_write_address_to_wb(wa4),
        .write_back_data_to_wb(wd4), .sign_extend_to_wb(se4),
        .conditionCodeRegister_to_wb(cc4), .reg_file_read_data2_to_wb(o24));

    typedef struct {
        logic        rd, wr, wbsel, rw;
        logic [2:0]  wa, cc;
        logic [15:0] res, d1, d2, se;
        logic [15:0] exp_wd;
        logic        exp_fault;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic w, input logic sel, input logic regw,
                         input logic [2:0] a, input logic [15:0] rr, input logic [15:0] dd);
        mrd = r; mwr = w; wbsel = sel; rw = regw; wa = a; res = rr; d1 = dd;
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 3'd0, 16'h0, 16'h0);
        cc = 3'b000; d2 = 16'h0; se = 16'h0;

        //            rd wr sel rw wa  cc      res       d1       d2       se       exp_wd                    fault
        vecs[0]  = '{0, 0, 0, 1, 3'd5, 3'b001, 16'h1234, 16'h0000, 16'h0A0A, 16'hFFF0, 16'h1234,                 1'b0};
        vecs[1]  = '{0, 1, 0, 0, 3'd1, 3'b010, 16'h0010, 16'hBEEF, 16'h0B0B, 16'h0001, 16'h0010,                 1'b0};
        vecs[2]  = '{1, 0, 1, 1, 3'd3, 3'b100, 16'h0010, 16'h0000, 16'h0C0C, 16'h0002, 16'hBEEF,                 1'b0};
        vecs[3]  = '{0, 0, 1, 1, 3'd2, 3'b000, 16'h4444, 16'h0000, 16'h0D0D, 16'h0003, 16'h0000,                 1'b0};
        vecs[4]  = '{1, 1, 1, 1, 3'd4, 3'b011, 16'h0007, 16'h5555, 16'h0E0E, 16'h0004, 16'h0007,                 1'b0};
        vecs[5]  = '{1, 0, 1, 1, 3'd6, 3'b101, 16'h0007, 16'h0000, 16'h0F0F, 16'h0005, 16'h5555,                 1'b0};
        vecs[6]  = '{0, 1, 0, 0, 3'd7, 3'b110, 16'h07FF, 16'hA5A5, 16'h1010, 16'h0006, 16'h07FF,                 1'b0};
        vecs[7]  = '{1, 0, 1, 1, 3'd7, 3'b111, 16'h07FF, 16'h0000, 16'h1111, 16'h0007, 16'hA5A5,                 1'b0};
        vecs[8]  = '{0, 1, 0, 0, 3'd1, 3'b000, 16'h8010, 16'h1111, 16'h1212, 16'h0008, 16'h8010,                 CHK};
        vecs[9]  = '{1, 0, 1, 1, 3'd2, 3'b001, 16'h0010, 16'h0000, 16'h1313, 16'h0009, CHK ? 16'hBEEF : 16'h1111, 1'b0};
        vecs[10] = '{1, 0, 1, 1, 3'd3, 3'b010, 16'h8010, 16'h0000, 16'h1414, 16'h000A, CHK ? 16'h0000 : 16'h1111, CHK};

        // Reset state
        @(negedge clk); @(negedge clk);
        chk("rst_rw1", {15'd0, rw1}, 16'h0);
        chk("rst_wd1", wd1, 16'h0);
        chk("rst_fault1", {15'd0, ft1}, 16'h0);
        chk("rst_stall4", {15'd0, st4}, 16'h0);
        reset = 1'b0;

        // Single-cycle table (latency-1 instance)
        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].rd, vecs[i].wr, vecs[i].wbsel, vecs[i].rw, vecs[i].wa, vecs[i].res, vecs[i].d1);
            cc = vecs[i].cc; d2 = vecs[i].d2; se = vecs[i].se;
            #1;
            chk($sformatf("v%0d_stall", i), {15'd0, st1}, 16'h0);
            cyc();
            chk($sformatf("v%0d_wd", i), wd1, vecs[i].exp_wd);
            chk($sformatf("v%0d_rw", i), {15'd0, rw1}, {15'd0, vecs[i].rw});
            chk($sformatf("v%0d_wa", i), {13'd0, wa1}, {13'd0, vecs[i].wa});
            chk($sformatf("v%0d_cc", i), {13'd0, cc1}, {13'd0, vecs[i].cc});
            chk($sformatf("v%0d_se", i), se1, vecs[i].se);
            chk($sformatf("v%0d_d2", i), o21, vecs[i].d2);
            chk($sformatf("v%0d_fault", i), {15'd0, ft1}, {15'd0, vecs[i].exp_fault});
        end
        drive(0, 0, 0, 0, 3'd0, 16'h0, 16'h0);
        cyc();
        chk("fault_one_cycle", {15'd0, ft1}, 16'h0);

        // Wait states, latency 3: store 0x00AA to 0x20, then load it back
        @(negedge clk); reset = 1'b1; @(negedge clk); reset = 1'b0;
        cc = 3'b000; d2 = 16'h0; se = 16'h0;
        drive(0, 1, 0, 0, 3'd0, 16'h0020, 16'h00AA);
        #1; chk("l3_st_stall0", {15'd0, st3}, 16'h1);
        cyc(); cyc(); cyc();
        drive(1, 0, 1, 1, 3'd6, 16'h0020, 16'h0000);
        #1; chk("l3_ld_stall0", {15'd0, st3}, 16'h1);
        cyc();
        chk("l3_bub1_rw", {15'd0, rw3}, 16'h0);
        chk("l3_bub1_wd", wd3, 16'h0);
        chk("l3_stall1", {15'd0, st3}, 16'h1);
        cyc();
        chk("l3_bub2_rw", {15'd0, rw3}, 16'h0);
        chk("l3_stall2", {15'd0, st3}, 16'h0);
        cyc();
        chk("l3_data", wd3, 16'h00AA);
        chk("l3_rw", {15'd0, rw3}, 16'h1);
        chk("l3_wa", {13'd0, wa3}, 16'h6);
        // Same access still presented: a new sequence starts with no gap
        chk("l3_b2b_stall", {15'd0, st3}, 16'h1);
        cyc();
        chk("l3_b2b_bub", {15'd0, rw3}, 16'h0);

        // Reset mid-wait, latency 4: mem[0x30] = 0x1234, then abort a store of 0xDEAD
        drive(0, 0, 0, 0, 3'd0, 16'h0, 16'h0);
        @(negedge clk); reset = 1'b1; @(negedge clk); reset = 1'b0;
        drive(0, 1, 0, 0, 3'd0, 16'h0030, 16'h1234);
        cyc(); cyc(); cyc(); cyc();
        drive(0, 0, 0, 0, 3'd0, 16'h0, 16'h0);
        cyc();
        drive(0, 1, 0, 1, 3'd2, 16'h0030, 16'hDEAD);
        cyc(); cyc();
        chk("l4_in_wait", {15'd0, st4}, 16'h1);
        reset = 1'b1;
        #1;
        chk("l4_rst_stall", {15'd0, st4}, 16'h0);
        chk("l4_rst_wd", wd4, 16'h0);
        chk("l4_rst_rw", {15'd0, rw4}, 16'h0);
        chk("l4_rst_wa", {13'd0, wa4}, 16'h0);
        cyc();
        drive(0, 0, 0, 0, 3'd0, 16'h0, 16'h0);
        @(negedge clk); reset = 1'b0;
        drive(1, 0, 1, 1, 3'd5, 16'h0030, 16'h0000);
        cyc(); cyc(); cyc(); cyc();
        chk("l4_mem_kept", wd4, 16'h1234);
        chk("l4_ld_rw", {15'd0, rw4}, 16'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
